// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state codes and mux select codes.
// The pc_source codes are also used by the PC-source mux in the datapath.
package mips_defs;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_MEM,
    CLS_BEQ,
    CLS_ADDI,
    CLS_J,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select from the current state.
module mips_mc_control
  import mips_defs::*;
#(
  parameter int OPW       = 6,
  parameter bit HANDSHAKE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           i_or_d,
  output logic           mem_read,
  output logic           mem_write,
  output logic           ir_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           reg_write,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_source,
  output logic           illegal_op,
  output logic [3:0]     state
);

  state_t    cur_state;
  state_t    nxt_state;
  op_class_t op_class;
  logic      ready;
  logic [5:0] op6;

  function automatic op_class_t decode_class(input logic [5:0] op);
    case (op)
      OP_RTYPE: return CLS_RTYPE;
      OP_LW,
      OP_SW:    return CLS_MEM;
      OP_BEQ:   return CLS_BEQ;
      OP_ADDI:  return CLS_ADDI;
      OP_J:     return CLS_J;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

  assign op6      = 6'(opcode);
  assign op_class = decode_class(op6);
  assign ready    = HANDSHAKE ? mem_ready : 1'b1;
  assign state    = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_FETCH;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_class)
          CLS_MEM:   nxt_state = S_MEMADR;
          CLS_RTYPE: nxt_state = S_EXEC;
          CLS_BEQ:   nxt_state = S_BRANCH;
          CLS_ADDI:  nxt_state = S_ADDIEX;
          CLS_J:     nxt_state = S_JUMP;
          default:   nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt_state = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt_state = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // IR and PC only load on the cycle the fetch actually completes, so each fires once per visit.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = ready;
        pc_write  = ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = (op_class == CLS_ILLEGAL);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed-vector bench for mips_mc_control: a table of per-cycle {opcode, mem_ready, state, controls}
// records walked in order, plus hand-written reset sequences around it.
module tb_mips_mc_control;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [16:0] act_ctl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [16:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];

  // Control bit layout: pcw pcwc iord mr mw irw m2r rd rw asa asb[2] aop[2] ps[2] ill
  localparam logic [16:0] PCW  = 17'h1 << 16;
  localparam logic [16:0] PCWC = 17'h1 << 15;
  localparam logic [16:0] IORD = 17'h1 << 14;
  localparam logic [16:0] MR   = 17'h1 << 13;
  localparam logic [16:0] MW   = 17'h1 << 12;
  localparam logic [16:0] IRW  = 17'h1 << 11;
  localparam logic [16:0] M2R  = 17'h1 << 10;
  localparam logic [16:0] RD   = 17'h1 << 9;
  localparam logic [16:0] RW   = 17'h1 << 8;
  localparam logic [16:0] ASA  = 17'h1 << 7;
  localparam logic [16:0] ILL  = 17'h1;

  function automatic logic [16:0] asb(input logic [1:0] v);
    return {10'b0, v, 5'b0};
  endfunction
  function automatic logic [16:0] aop(input logic [1:0] v);
    return {12'b0, v, 3'b0};
  endfunction
  function automatic logic [16:0] ps(input logic [1:0] v);
    return {14'b0, v, 1'b0};
  endfunction

  always #5 clk = ~clk;

  mips_mc_control #(.OPW(6), .HANDSHAKE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .mem_to_reg   (mem_to_reg),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .illegal_op   (illegal_op),
    .state        (state)
  );

  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic [3:0] est, input logic [16:0] ectl);
    check_val({tag, " state"}, {28'b0, state}, {28'b0, est});
    check_val({tag, " ctl"}, {15'b0, act_ctl}, {15'b0, ectl});
  endtask

  task automatic apply_stimulus(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input logic [16:0] ctl);
    vec_t v;
    v.opcode    = op;
    v.mem_ready = rdy;
    v.exp_state = st;
    v.exp_ctl   = ctl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [16:0] go, wait_f, dec;
    go     = PCW | IRW | MR | asb(2'b01);
    wait_f = MR | asb(2'b01);
    dec    = asb(2'b11);

    add(OP_LW, 1'b1, 4'd0, go);
    add(OP_LW, 1'b1, 4'd1, dec);
    add(OP_LW, 1'b1, 4'd2, ASA | asb(2'b10));
    add(OP_LW, 1'b1, 4'd3, MR | IORD);
    add(OP_LW, 1'b1, 4'd4, RW | M2R);

    add(OP_SW, 1'b1, 4'd0, go);
    add(OP_SW, 1'b1, 4'd1, dec);
    add(OP_SW, 1'b1, 4'd2, ASA | asb(2'b10));
    add(OP_SW, 1'b0, 4'd5, MW | IORD);
    add(OP_SW, 1'b0, 4'd5, MW | IORD);
    add(OP_SW, 1'b1, 4'd5, MW | IORD);

    add(OP_RTYPE, 1'b1, 4'd0, go);
    add(OP_RTYPE, 1'b1, 4'd1, dec);
    add(OP_RTYPE, 1'b1, 4'd6, ASA | aop(2'b10));
    add(OP_RTYPE, 1'b1, 4'd7, RW | RD);

    add(OP_BEQ, 1'b1, 4'd0, go);
    add(OP_BEQ, 1'b1, 4'd1, dec);
    add(OP_BEQ, 1'b1, 4'd8, ASA | aop(2'b01) | PCWC | ps(2'b01));

    add(OP_J, 1'b1, 4'd0, go);
    add(OP_J, 1'b1, 4'd1, dec);
    add(OP_J, 1'b1, 4'd11, PCW | ps(2'b10));

    add(OP_ADDI, 1'b1, 4'd0, go);
    add(OP_ADDI, 1'b1, 4'd1, dec);
    add(OP_ADDI, 1'b1, 4'd9, ASA | asb(2'b10));
    add(OP_ADDI, 1'b1, 4'd10, RW);

    // LW stretched by one wait cycle in FETCH and one in MEMRD
    add(OP_LW, 1'b0, 4'd0, wait_f);
    add(OP_LW, 1'b1, 4'd0, go);
    add(OP_LW, 1'b1, 4'd1, dec);
    add(OP_LW, 1'b1, 4'd2, ASA | asb(2'b10));
    add(OP_LW, 1'b0, 4'd3, MR | IORD);
    add(OP_LW, 1'b1, 4'd3, MR | IORD);
    add(OP_LW, 1'b1, 4'd4, RW | M2R);

    add(6'b111111, 1'b1, 4'd0, go);
    add(6'b111111, 1'b1, 4'd1, dec | ILL);
    add(OP_RTYPE, 1'b0, 4'd0, wait_f);

    rst       = 1'b1;
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("reset", 4'd0, wait_f);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(OP_RTYPE, 1'b0);
      check_output($sformatf("fetch_wait%0d", i), 4'd0, wait_f);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].opcode, vecs[i].mem_ready);
      check_output($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctl);
    end

    // Reset in the middle of EXEC must return to FETCH without waiting for a clock edge
    apply_stimulus(OP_RTYPE, 1'b1);
    check_output("mid_fetch", 4'd0, go);
    apply_stimulus(OP_RTYPE, 1'b1);
    check_output("mid_decode", 4'd1, dec);
    apply_stimulus(OP_RTYPE, 1'b1);
    check_output("mid_exec", 4'd6, ASA | aop(2'b10));
    mem_ready = 1'b0;
    rst       = 1'b1;
    #1;
    check_output("async_rst", 4'd0, wait_f);
    @(negedge clk);
    #1;
    check_output("rst_held", 4'd0, wait_f);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(OP_RTYPE, 1'b0);
      check_output($sformatf("post_rst%0d", i), 4'd0, wait_f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
